// File: rtl/lieat_axi_rd_arbiter.sv
// rtl/lieat_axi_rd_arbiter.sv - N-master to 1-slave AXI read-channel (AR/R) arbiter
//
// Serialises single-beat reads from N masters onto one slave port with
// round-robin fairness and a single outstanding transaction. R responses
// are routed back to the master that won the address phase, and the
// returned RID is compared against the ID that was issued.
//
// Ports:
//   clock, reset        clock; asynchronous active-low reset
//   m_arvalid/m_arready per-master AR handshake (at most one ready bit set)
//   m_araddr/arsize/arid packed per-master AR fields, master i at slot i
//   m_rvalid/m_rready   per-master R handshake (at most one valid bit set)
//   m_rdata/m_rid       R payload broadcast to all masters
//   s_ar*               registered AR request towards the slave
//   s_r*                R response from the slave
//   rid_err             pulse during an R handshake whose RID mismatches

module lieat_axi_rd_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      m_arvalid,
    output logic [N-1:0]      m_arready,
    input  logic [N*AW-1:0]   m_araddr,
    input  logic [N*3-1:0]    m_arsize,
    input  logic [N*4-1:0]    m_arid,
    output logic [N-1:0]      m_rvalid,
    input  logic [N-1:0]      m_rready,
    output logic [DW-1:0]     m_rdata,
    output logic [3:0]        m_rid,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [AW-1:0]     s_araddr,
    output logic [2:0]        s_arsize,
    output logic [3:0]        s_arid,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DW-1:0]     s_rdata,
    input  logic [3:0]        s_rid,
    output logic              rid_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic            r_hs;

    // Round-robin search starting at ptr. The loop runs from the farthest
    // offset down to offset 0 so the nearest requester is the last writer.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (m_arvalid[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign r_hs    = (state == RESP) && s_rvalid && m_rready[grant];
    assign m_rdata = s_rdata;
    assign m_rid   = s_rid;

    always_comb begin
        state_nxt = state;
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        rid_err   = 1'b0;
        case (state)
            IDLE: begin
                // Ready is combinational from arvalid, but must stay low
                // while reset is held.
                if (pick_vld && reset) begin
                    m_arready[pick] = 1'b1;
                    state_nxt       = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                m_rvalid[grant] = s_rvalid;
                s_rready        = m_rready[grant];
                if (r_hs) begin
                    state_nxt = IDLE;
                    // s_arid still holds the ID that was issued.
                    rid_err   = (s_rid != s_arid);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            s_araddr <= '0;
            s_arsize <= '0;
            s_arid   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && pick_vld) begin
                grant    <= pick;
                s_araddr <= m_araddr[int'(pick) * AW +: AW];
                s_arsize <= m_arsize[int'(pick) * 3 +: 3];
                s_arid   <= m_arid[int'(pick) * 4 +: 4];
            end
            // Priority rotates past the master just served.
            if (r_hs) begin
                ptr <= (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lieat_axi_rd_arbiter.sv
// tb/tb_lieat_axi_rd_arbiter.sv - self-checking bench for lieat_axi_rd_arbiter
module tb_lieat_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      m_arvalid;
    logic [N-1:0]      m_arready;
    logic [N*AW-1:0]   m_araddr;
    logic [N*3-1:0]    m_arsize;
    logic [N*4-1:0]    m_arid;
    logic [N-1:0]      m_rvalid;
    logic [N-1:0]      m_rready;
    logic [DW-1:0]     m_rdata;
    logic [3:0]        m_rid;
    logic              s_arvalid;
    logic              s_arready;
    logic [AW-1:0]     s_araddr;
    logic [2:0]        s_arsize;
    logic [3:0]        s_arid;
    logic              s_rvalid;
    logic              s_rready;
    logic [DW-1:0]     s_rdata;
    logic [3:0]        s_rid;
    logic              rid_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lieat_axi_rd_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arsize(m_arsize), .m_arid(m_arid), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arsize(s_arsize), .s_arid(s_arid), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .rid_err(rid_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic [2:0] sz, input logic [3:0] id);
        m_araddr[i*AW +: AW] = a;
        m_arsize[i*3 +: 3]   = sz;
        m_arid[i*4 +: 4]     = id;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0;
        s_rdata = '0; s_rid = '0; m_araddr = '0; m_arsize = '0; m_arid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Reference round-robin choice: first requester at ptr, ptr+1, ... mod N.
    function automatic int rr_pick(input int p, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        set_m(0, 32'h1234_5678, 3'd3, 4'h9);
        m_arvalid = '1; m_rready = '1; s_rvalid = 1'b1; s_arready = 1'b1;
        step();
        sample();
        checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL rst_arready act=%b exp=000", m_arready); end
        checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid act=%b exp=000", m_rvalid); end
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid act=%b exp=0", s_arvalid); end
        checks++; if (s_rready !== 1'b0) begin errors++; $display("FAIL rst_s_rready act=%b exp=0", s_rready); end
        checks++; if ({s_araddr, s_arsize, s_arid} !== '0) begin errors++; $display("FAIL rst_s_fields act=%h/%h/%h exp=0", s_araddr, s_arsize, s_arid); end
        checks++; if (rid_err !== 1'b0) begin errors++; $display("FAIL rst_rid_err act=%b exp=0", rid_err); end
        do_reset();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        do_reset();
        d = {$urandom, $urandom};
        set_m(0, 32'h8000_0000, 3'b010, 4'h2);
        m_arvalid = 3'b001;
        sample();
        checks++; if (m_arready !== 3'b001) begin errors++; $display("FAIL t1_arready act=%b exp=001", m_arready); end
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL t1_arvalid_early act=%b exp=0", s_arvalid); end
        step();
        m_arvalid = '0; s_arready = 1'b1;
        sample();
        checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL t1_s_arvalid act=%b exp=1", s_arvalid); end
        checks++; if (s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL t1_s_araddr act=%h exp=80000000", s_araddr); end
        checks++; if (s_arid !== 4'h2 || s_arsize !== 3'b010) begin errors++; $display("FAIL t1_s_id_size act=%h/%b exp=2/010", s_arid, s_arsize); end
        checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL t1_arready_addr act=%b exp=000", m_arready); end
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = d; s_rid = 4'h2; m_rready = '1;
        sample();
        checks++; if (m_rvalid !== 3'b001) begin errors++; $display("FAIL t1_m_rvalid act=%b exp=001", m_rvalid); end
        checks++; if (m_rdata !== d) begin errors++; $display("FAIL t1_m_rdata act=%h exp=%h", m_rdata, d); end
        checks++; if (s_rready !== 1'b1 || rid_err !== 1'b0) begin errors++; $display("FAIL t1_rready_rid act=%b/%b exp=1/0", s_rready, rid_err); end
        step();
        s_rvalid = 1'b0;
        sample();
        checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL t1_rvalid_after act=%b exp=000", m_rvalid); end
        step();
    endtask

    task automatic test_contention();
        int cnt[N];
        int order[$];
        bit busy;
        bit rph;
        int g;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        busy = 0; rph = 0;
        reset = 1'b0;
        clear_inputs();
        m_arvalid = 3'b011; s_arready = 1'b1; m_rready = '1;
        step();
        sample();
        checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL t2_arready_in_reset act=%b exp=000", m_arready); end
        step();
        reset = 1'b1;
        for (int cyc = 0; cyc < 100 && order.size() < 8; cyc++) begin
            m_arvalid[0] = (cnt[0] < 4);
            m_arvalid[1] = (cnt[1] < 4);
            s_rvalid = rph;
            sample();
            if (m_arready !== 3'b000) begin
                checks++; if (busy || !$onehot(m_arready)) begin errors++; $display("FAIL t2_overlap arready=%b busy=%0d exp=single grant when free", m_arready, busy); end
                g = m_arready[2] ? 2 : (m_arready[1] ? 1 : 0);
                order.push_back(g);
                cnt[g]++;
                busy = 1;
            end else if (s_arvalid && s_arready) begin
                rph = 1;
            end else if ((m_rvalid !== 3'b000) && s_rready) begin
                rph = 0; busy = 0;
            end
            step();
        end
        checks++; if (order.size() != 8) begin errors++; $display("FAIL t2_grant_count act=%0d exp=8", order.size()); end
        for (int k = 0; k < order.size(); k++) begin
            checks++; if (order[k] != k % 2) begin errors++; $display("FAIL t2_order[%0d] act=%0d exp=%0d", k, order[k], k % 2); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_m(1, 32'h0000_4440, 3'b011, 4'h1);
        set_m(0, 32'h0000_0100, 3'b010, 4'h6);
        m_arvalid = 3'b010;
        sample();
        checks++; if (m_arready !== 3'b010) begin errors++; $display("FAIL t3_grant1 act=%b exp=010", m_arready); end
        step();
        m_arvalid = 3'b001; s_arready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_4440 || s_arid !== 4'h1) begin errors++; $display("FAIL t3_ar_hold act=%b/%h/%h exp=1/00004440/1", s_arvalid, s_araddr, s_arid); end
            checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL t3_no_grant_addr act=%b exp=000", m_arready); end
            step();
        end
        s_arready = 1'b1;
        sample();
        checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL t3_ar_final act=%b exp=1", s_arvalid); end
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'h1; s_rdata = 64'hDEAD_BEEF_0000_0001; m_rready = 3'b101;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++; if (m_rvalid !== 3'b010 || s_rready !== 1'b0) begin errors++; $display("FAIL t3_r_stall rvalid=%b rready=%b exp=010/0", m_rvalid, s_rready); end
            checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL t3_no_grant_resp act=%b exp=000", m_arready); end
            step();
        end
        m_rready = '1;
        sample();
        checks++; if (m_rvalid !== 3'b010 || s_rready !== 1'b1) begin errors++; $display("FAIL t3_r_hs rvalid=%b rready=%b exp=010/1", m_rvalid, s_rready); end
        step();
        s_rvalid = 1'b0;
        sample();
        checks++; if (m_arready !== 3'b001) begin errors++; $display("FAIL t3_next_grant act=%b exp=001", m_arready); end
        step();
    endtask

    task automatic test_rid();
        do_reset();
        set_m(0, 32'h0000_1000, 3'b011, 4'h3);
        m_arvalid = 3'b001;
        sample();
        step();
        m_arvalid = '0; s_arready = 1'b1;
        sample();
        checks++; if (s_arid !== 4'h3) begin errors++; $display("FAIL t4_s_arid act=%h exp=3", s_arid); end
        step();
        s_arready = 1'b0; m_rready = '1;
        sample();
        checks++; if (rid_err !== 1'b0) begin errors++; $display("FAIL t4_rid_err_wait act=%b exp=0", rid_err); end
        step();
        s_rvalid = 1'b1; s_rid = 4'h5;
        sample();
        checks++; if (rid_err !== 1'b1) begin errors++; $display("FAIL t4_rid_err_pulse act=%b exp=1", rid_err); end
        checks++; if (m_rvalid !== 3'b001) begin errors++; $display("FAIL t4_rvalid act=%b exp=001", m_rvalid); end
        step();
        s_rvalid = 1'b0;
        sample();
        checks++; if (rid_err !== 1'b0) begin errors++; $display("FAIL t4_rid_err_after act=%b exp=0", rid_err); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 32'h8000_0040, 3'b011, 4'hA);
        m_arvalid = 3'b001;
        sample();
        step();
        m_arvalid = '0; s_arready = 1'b1;
        sample();
        step();
        s_arready = 1'b0;
        sample();
        reset = 1'b0;
        s_rvalid = 1'b1; m_rready = '1; m_arvalid = 3'b111;
        #2;
        checks++; if ({m_arready, m_rvalid, s_arvalid, s_rready, rid_err} !== '0) begin errors++; $display("FAIL t5_outputs act=%b/%b/%b/%b/%b exp=0", m_arready, m_rvalid, s_arvalid, s_rready, rid_err); end
        checks++; if ({s_araddr, s_arsize, s_arid} !== '0) begin errors++; $display("FAIL t5_fields act=%h/%h/%h exp=0", s_araddr, s_arsize, s_arid); end
        step();
        step();
        reset = 1'b1;
        s_rvalid = 1'b0; m_rready = '0;
        set_m(1, 32'h0000_2220, 3'b001, 4'h7);
        m_arvalid = 3'b010;
        sample();
        checks++; if (m_arready !== 3'b010) begin errors++; $display("FAIL t5_regrant act=%b exp=010", m_arready); end
        step();
        m_arvalid = '0; s_arready = 1'b1;
        sample();
        checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_2220) begin errors++; $display("FAIL t5_s_ar act=%b/%h exp=1/00002220", s_arvalid, s_araddr); end
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'h7; m_rready = 3'b010;
        sample();
        checks++; if (m_rvalid !== 3'b010 || rid_err !== 1'b0) begin errors++; $display("FAIL t5_resp act=%b/%b exp=010/0", m_rvalid, rid_err); end
        step();
        s_rvalid = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        m_rready = '1; s_rid = 4'h7;
        for (int c = 0; c < 10; c++) begin
            s_rvalid = (c == 4 || c == 5);
            sample();
            checks++; if (m_arready !== 3'b000 || m_rvalid !== 3'b000) begin errors++; $display("FAIL t6_idle_mst c=%0d act=%b/%b exp=000/000", c, m_arready, m_rvalid); end
            checks++; if (s_rready !== 1'b0 || s_arvalid !== 1'b0 || rid_err !== 1'b0) begin errors++; $display("FAIL t6_idle_slv c=%0d act=%b/%b/%b exp=0/0/0", c, s_rready, s_arvalid, rid_err); end
            step();
        end
        s_rvalid = 1'b0;
        m_arvalid = 3'b100;
        sample();
        checks++; if (m_arready !== 3'b100) begin errors++; $display("FAIL t6_grant2 act=%b exp=100", m_arready); end
        step();
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        logic [31:0]   ra[N];
        logic [2:0]    rs[N];
        logic [3:0]    ri[N];
        logic [N-1:0]  exp_arr;
        logic [N-1:0]  exp_rv;
        int            mptr, gnt, pk, done;
        bit            busy, ar_done, rv_act, exp_err;
        bit            mhs, shs, rhs;
        logic [31:0]   ea;
        logic [2:0]    es;
        logic [3:0]    eid;
        do_reset();
        pend = '0; mptr = 0; gnt = 0; done = 0;
        busy = 0; ar_done = 0; rv_act = 0;
        ea = '0; es = '0; eid = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rs[i] = '0; ri[i] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = $urandom; rs[i] = 3'($urandom_range(0, 7)); ri[i] = 4'($urandom_range(0, 15));
                    set_m(i, ra[i], rs[i], ri[i]);
                end
            end
            m_arvalid = pend;
            m_rready  = N'($urandom);
            s_arready = 1'($urandom_range(0, 1));
            if (busy && ar_done && !rv_act && $urandom_range(0, 1) == 1) begin
                rv_act  = 1;
                s_rdata = {$urandom, $urandom};
                s_rid   = ($urandom_range(0, 5) == 0) ? (eid ^ 4'($urandom_range(1, 15))) : eid;
            end
            s_rvalid = rv_act;
            sample();
            pk = rr_pick(mptr, pend);
            exp_arr = '0;
            if (!busy && pk >= 0) exp_arr[pk] = 1'b1;
            exp_rv = '0;
            if (busy && ar_done && rv_act) exp_rv[gnt] = 1'b1;
            exp_err = busy && ar_done && rv_act && m_rready[gnt] && (s_rid != eid);
            checks++; if (m_arready !== exp_arr) begin errors++; $display("FAIL rnd_arready cyc=%0d act=%b exp=%b", cyc, m_arready, exp_arr); end
            checks++; if (s_arvalid !== (busy && !ar_done)) begin errors++; $display("FAIL rnd_s_arvalid cyc=%0d act=%b exp=%b", cyc, s_arvalid, busy && !ar_done); end
            if (busy && !ar_done) begin
                checks++; if (s_araddr !== ea || s_arsize !== es || s_arid !== eid) begin errors++; $display("FAIL rnd_s_fields cyc=%0d act=%h/%h/%h exp=%h/%h/%h", cyc, s_araddr, s_arsize, s_arid, ea, es, eid); end
            end
            checks++; if (m_rvalid !== exp_rv) begin errors++; $display("FAIL rnd_m_rvalid cyc=%0d act=%b exp=%b", cyc, m_rvalid, exp_rv); end
            checks++; if (s_rready !== (busy && ar_done && m_rready[gnt])) begin errors++; $display("FAIL rnd_s_rready cyc=%0d act=%b exp=%b", cyc, s_rready, busy && ar_done && m_rready[gnt]); end
            checks++; if (rid_err !== exp_err) begin errors++; $display("FAIL rnd_rid_err cyc=%0d act=%b exp=%b", cyc, rid_err, exp_err); end
            checks++; if (m_rdata !== s_rdata || m_rid !== s_rid) begin errors++; $display("FAIL rnd_r_bcast cyc=%0d act=%h/%h exp=%h/%h", cyc, m_rdata, m_rid, s_rdata, s_rid); end
            mhs = (exp_arr != '0);
            shs = busy && !ar_done && s_arready;
            rhs = busy && ar_done && rv_act && m_rready[gnt];
            step();
            if (rhs) begin busy = 0; ar_done = 0; rv_act = 0; mptr = (gnt + 1) % N; done++; end
            if (shs) ar_done = 1;
            if (mhs) begin
                busy = 1; gnt = pk; ea = ra[pk]; es = rs[pk]; eid = ri[pk]; pend[pk] = 1'b0;
            end
        end
        checks++; if (done < 20) begin errors++; $display("FAIL rnd_progress act=%0d exp=>=20", done); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_rid();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
